// File: rtl/otter_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_io_pkg
//  Description : Shared definitions for the OTTER IOBUS responder. Holds the
//                default bank base address, register offsets, TMR_CTRL bit
//                indices, the register-select enum and the address decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    // Register offsets from the bank base
    localparam logic [31:0] OFF_SW       = 32'h0000_0000;
    localparam logic [31:0] OFF_LEDS     = 32'h0000_0020;
    localparam logic [31:0] OFF_SSEG     = 32'h0000_0040;
    localparam logic [31:0] OFF_TMR_CTRL = 32'h0000_0060;
    localparam logic [31:0] OFF_TMR_CMP  = 32'h0000_0064;
    localparam logic [31:0] OFF_TMR_CNT  = 32'h0000_0068;
    localparam logic [31:0] OFF_IRQ_STAT = 32'h0000_006C;

    // TMR_CTRL bit positions
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IEN         = 2;
    localparam int CTRL_WIDTH       = 3;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_SW   = 3'd1,
        SEL_LEDS = 3'd2,
        SEL_SSEG = 3'd3,
        SEL_CTRL = 3'd4,
        SEL_CMP  = 3'd5,
        SEL_CNT  = 3'd6,
        SEL_STAT = 3'd7
    } io_sel_e;

    // Full 32-bit decode: an address below the base wraps to a huge offset
    // and therefore falls into SEL_NONE.
    function automatic io_sel_e io_decode(input logic [31:0] addr,
                                          input logic [31:0] base);
        logic [31:0] off;
        off       = addr - base;
        io_decode = SEL_NONE;
        case (off)
            OFF_SW:       io_decode = SEL_SW;
            OFF_LEDS:     io_decode = SEL_LEDS;
            OFF_SSEG:     io_decode = SEL_SSEG;
            OFF_TMR_CTRL: io_decode = SEL_CTRL;
            OFF_TMR_CMP:  io_decode = SEL_CMP;
            OFF_TMR_CNT:  io_decode = SEL_CNT;
            OFF_IRQ_STAT: io_decode = SEL_STAT;
            default:      io_decode = SEL_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : otter_io_timer
//  Description : 32-bit compare timer with one-shot / auto-reload modes, a
//                sticky pending flag (write-1-to-clear) and a registered
//                interrupt output.
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                ctrl_we_i         - write strobe for TMR_CTRL
//                cmp_we_i          - write strobe for TMR_CMP (also clears CNT)
//                stat_we_i         - write strobe for IRQ_STAT (W1C on bit 0)
//                wdata_i           - CPU write data
//                ctrl_o/cmp_o/cnt_o- register contents for readback
//                pend_o            - pending flag
//                intr_o            - PEND & IEN, straight from a flop
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_io_timer
    import otter_io_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ctrl_we_i,
    input  logic                  cmp_we_i,
    input  logic                  stat_we_i,
    input  logic [31:0]           wdata_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [31:0]           cmp_o,
    output logic [31:0]           cnt_o,
    output logic                  pend_o,
    output logic                  intr_o
);

    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [31:0]           cmp_q, cmp_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  intr_q;
    logic                  match_w;

    // A CMP write restarts the count and suppresses any match this cycle.
    assign match_w = ctrl_q[CTRL_EN] && (cnt_q == cmp_q) && !cmp_we_i;

    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;

        if (cmp_we_i) begin
            cmp_d = wdata_i;
            cnt_d = '0;
        end else if (match_w) begin
            if (ctrl_q[CTRL_AUTO_RELOAD]) begin
                cnt_d = '0;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;     // one-shot: CNT holds at CMP
            end
        end else if (ctrl_q[CTRL_EN]) begin
            cnt_d = cnt_q + 32'd1;
        end

        // Explicit CTRL write wins over the one-shot EN clear.
        if (ctrl_we_i) begin
            ctrl_d = wdata_i[CTRL_WIDTH-1:0];
        end

        // Set beats clear when a match and a W1C land together.
        if (match_w) begin
            pend_d = 1'b1;
        end else if (stat_we_i && wdata_i[0]) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            cmp_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            cmp_q  <= cmp_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            // Registered from next-state values so INTR tracks PEND & IEN
            // exactly, but leaves the block on a single flop.
            intr_q <= pend_d & ctrl_d[CTRL_IEN];
        end
    end

    assign ctrl_o = ctrl_q;
    assign cmp_o  = cmp_q;
    assign cnt_o  = cnt_q;
    assign pend_o = pend_q;
    assign intr_o = intr_q;

endmodule
`default_nettype wire

// File: rtl/otter_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : otter_io_responder
//  Description : IOBUS register bank for the OTTER CPU: switch input with a
//                two-flop synchronizer, LED and seven-segment registers, and
//                a compare timer that drives the CPU interrupt.
//  Ports       : CLK, RESET   - clock, synchronous active-high reset
//                IOBUS_ADDR   - CPU byte address
//                IOBUS_OUT    - CPU write data
//                IOBUS_WR     - CPU write strobe
//                IOBUS_IN     - combinational read data to the CPU
//                SWITCHES     - asynchronous board switches
//                LEDS, SSEG   - output register contents
//                INTR         - level interrupt to the CPU
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_io_responder
    import otter_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic [LED_WIDTH-1:0] SSEG,
    output logic                 INTR
);

    io_sel_e               sel_w;
    logic [31:0]           rdata_w;
    logic [LED_WIDTH-1:0]  leds_q;
    logic [LED_WIDTH-1:0]  sseg_q;
    logic [SW_WIDTH-1:0]   sw_meta_q;
    logic [SW_WIDTH-1:0]   sw_sync_q;
    logic [CTRL_WIDTH-1:0] tmr_ctrl_w;
    logic [31:0]           tmr_cmp_w;
    logic [31:0]           tmr_cnt_w;
    logic                  tmr_pend_w;
    logic                  tmr_intr_w;

    assign sel_w = io_decode(IOBUS_ADDR, IO_BASE);

    // ---------------------------------------------------------------------
    // Output registers and switch synchronizer
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            leds_q    <= '0;
            sseg_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            if (IOBUS_WR && sel_w == SEL_LEDS) begin
                leds_q <= IOBUS_OUT[LED_WIDTH-1:0];
            end
            if (IOBUS_WR && sel_w == SEL_SSEG) begin
                sseg_q <= IOBUS_OUT[LED_WIDTH-1:0];
            end
            sw_meta_q <= SWITCHES;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ---------------------------------------------------------------------
    // Timer
    // ---------------------------------------------------------------------
    otter_io_timer u_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .ctrl_we_i (IOBUS_WR && sel_w == SEL_CTRL),
        .cmp_we_i  (IOBUS_WR && sel_w == SEL_CMP),
        .stat_we_i (IOBUS_WR && sel_w == SEL_STAT),
        .wdata_i   (IOBUS_OUT),
        .ctrl_o    (tmr_ctrl_w),
        .cmp_o     (tmr_cmp_w),
        .cnt_o     (tmr_cnt_w),
        .pend_o    (tmr_pend_w),
        .intr_o    (tmr_intr_w)
    );

    // ---------------------------------------------------------------------
    // Read mux: zero-extended fields, unmapped reads return zero
    // ---------------------------------------------------------------------
    always_comb begin
        rdata_w = '0;
        case (sel_w)
            SEL_SW:   rdata_w[SW_WIDTH-1:0]   = sw_sync_q;
            SEL_LEDS: rdata_w[LED_WIDTH-1:0]  = leds_q;
            SEL_SSEG: rdata_w[LED_WIDTH-1:0]  = sseg_q;
            SEL_CTRL: rdata_w[CTRL_WIDTH-1:0] = tmr_ctrl_w;
            SEL_CMP:  rdata_w                 = tmr_cmp_w;
            SEL_CNT:  rdata_w                 = tmr_cnt_w;
            SEL_STAT: rdata_w[0]              = tmr_pend_w;
            default:  rdata_w                 = '0;
        endcase
    end

    assign IOBUS_IN = rdata_w;
    assign LEDS     = leds_q;
    assign SSEG     = sseg_q;
    assign INTR     = tmr_intr_w;

endmodule
`default_nettype wire

// File: tb/tb_otter_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_io_responder
//  Description : Self-checking bench for otter_io_responder. Each bus cycle
//                pushes its expected outputs into a scoreboard; a monitor on
//                the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_io_responder;

    localparam logic [31:0] B = 32'h1100_0000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES;
    logic [15:0] LEDS;
    logic [15:0] SSEG;
    logic        INTR;

    otter_io_responder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .SSEG       (SSEG),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: the register bank as plain variables
    // ------------------------------------------------------------------
    logic [15:0] m_leds, m_sseg, m_sw1, m_sw2;
    logic        m_en, m_ar, m_ien, m_pend;
    logic [31:0] m_cmp, m_cnt;

    function automatic void m_reset();
        m_leds = 0; m_sseg = 0; m_sw1 = 0; m_sw2 = 0;
        m_en = 0; m_ar = 0; m_ien = 0; m_pend = 0;
        m_cmp = 0; m_cnt = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == B + 32'h00) return {16'h0, m_sw2};
        if (a == B + 32'h20) return {16'h0, m_leds};
        if (a == B + 32'h40) return {16'h0, m_sseg};
        if (a == B + 32'h60) return {29'h0, m_ien, m_ar, m_en};
        if (a == B + 32'h64) return m_cmp;
        if (a == B + 32'h68) return m_cnt;
        if (a == B + 32'h6C) return {31'h0, m_pend};
        return 32'h0;
    endfunction

    // One clock edge of the register bank, given the inputs seen at that edge.
    function automatic void m_step(input logic [31:0] a, input logic [31:0] d,
                                   input logic w, input logic rst, input logic [15:0] sw);
        logic hit_cmp, hit_ctrl, hit_stat, hit;
        if (rst) begin
            m_reset();
            return;
        end
        hit_cmp  = w && (a == B + 32'h64);
        hit_ctrl = w && (a == B + 32'h60);
        hit_stat = w && (a == B + 32'h6C);
        // a compare hit only counts if CMP is not being rewritten this edge
        hit = m_en && (m_cnt == m_cmp) && !hit_cmp;
        m_sw2 = m_sw1;
        m_sw1 = sw;
        if (w && a == B + 32'h20) m_leds = d[15:0];
        if (w && a == B + 32'h40) m_sseg = d[15:0];
        if (hit_cmp) begin
            m_cmp = d;
            m_cnt = 0;
        end else if (hit) begin
            if (m_ar) m_cnt = 0;
            else      m_en  = 0;
        end else if (m_en) begin
            m_cnt = m_cnt + 1;
        end
        if (hit_ctrl) begin
            m_en = d[0]; m_ar = d[1]; m_ien = d[2];
        end
        if (hit)                   m_pend = 1;
        else if (hit_stat && d[0]) m_pend = 0;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [95:0] name;
        logic [31:0] rd;
        logic [15:0] leds;
        logic [15:0] sseg;
        logic        intr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (IOBUS_IN !== e.rd) begin
                bad++;
                $display("FAIL %0s rdata got=%h want=%h @%0t", e.name, IOBUS_IN, e.rd, $time);
            end
            total++;
            if (LEDS !== e.leds) begin
                bad++;
                $display("FAIL %0s leds got=%h want=%h @%0t", e.name, LEDS, e.leds, $time);
            end
            total++;
            if (SSEG !== e.sseg) begin
                bad++;
                $display("FAIL %0s sseg got=%h want=%h @%0t", e.name, SSEG, e.sseg, $time);
            end
            total++;
            if (INTR !== e.intr) begin
                bad++;
                $display("FAIL %0s intr got=%b want=%b @%0t", e.name, INTR, e.intr, $time);
            end
        end
    end

    // One bus cycle. Read data is expected from the model unless lit_en
    // supplies a hand-derived value.
    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [95:0] nm, input logic lit_en, input logic [31:0] lit);
        exp_t e;
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = w;
        e.name = nm;
        e.rd   = lit_en ? lit : m_read(a);
        e.leds = m_leds;
        e.sseg = m_sseg;
        e.intr = m_pend & m_ien;
        sb.push_back(e);
        @(posedge CLK);
        m_step(a, d, w, RESET, SWITCHES);
        #1;
    endtask

    int offs[11] = '{32'h00, 32'h20, 32'h40, 32'h60, 32'h64, 32'h68, 32'h6C,
                     32'h10, 32'h04, 32'h70, 32'h0100_0020};

    initial begin
        RESET = 1'b1; IOBUS_ADDR = 0; IOBUS_OUT = 0; IOBUS_WR = 0; SWITCHES = 0;
        repeat (2) @(posedge CLK);
        m_reset();
        #1;
        RESET = 1'b0;

        // Reset state, LED write/readback, unmapped access
        tick(B + 32'h20, 0, 0, "rst_leds", 1, 32'h0);
        tick(B + 32'h00, 0, 0, "rst_sw", 1, 32'h0);
        tick(B + 32'h6C, 0, 0, "rst_stat", 1, 32'h0);
        tick(B + 32'h20, 32'h0001_A5A5, 1, "led_wr", 1, 32'h0);
        tick(B + 32'h20, 0, 0, "led_rd", 1, 32'h0000_A5A5);
        tick(B + 32'h10, 32'hDEAD_BEEF, 1, "unmap_wr", 1, 32'h0);
        tick(B + 32'h10, 0, 0, "unmap_rd", 1, 32'h0);
        tick(B + 32'h20, 0, 0, "led_keep", 1, 32'h0000_A5A5);

        // Switch synchronizer latency
        SWITCHES = 16'h00F0;
        tick(B + 32'h00, 0, 0, "sw_c0", 1, 32'h0);
        tick(B + 32'h00, 0, 0, "sw_c1", 1, 32'h0);
        tick(B + 32'h00, 0, 0, "sw_c2", 1, 32'h0000_00F0);

        // One-shot match
        tick(B + 32'h64, 32'd5, 1, "os_cmp", 0, 0);
        tick(B + 32'h60, 32'd5, 1, "os_ctrl", 0, 0);
        for (int i = 0; i < 6; i++) tick(B + 32'h68, 0, 0, "os_cnt", 1, i);
        tick(B + 32'h6C, 0, 0, "os_pend", 1, 32'h1);
        tick(B + 32'h60, 0, 0, "os_en_off", 1, 32'h4);
        tick(B + 32'h68, 0, 0, "os_hold", 1, 32'h5);
        tick(B + 32'h6C, 32'h1, 1, "os_w1c", 1, 32'h1);
        tick(B + 32'h6C, 0, 0, "os_clr", 1, 32'h0);

        // Auto-reload, W1C on a match cycle, IEN clear
        tick(B + 32'h64, 32'd3, 1, "ar_cmp", 0, 0);
        tick(B + 32'h60, 32'd7, 1, "ar_ctrl", 0, 0);
        for (int i = 0; i < 11; i++) tick(B + 32'h68, 0, 0, "ar_cnt", 1, i % 4);
        tick(B + 32'h6C, 32'h1, 1, "ar_w1c", 1, 32'h1);
        tick(B + 32'h6C, 0, 0, "ar_setwins", 1, 32'h1);
        tick(B + 32'h60, 32'd3, 1, "ien_off", 0, 0);
        tick(B + 32'h6C, 0, 0, "ien_pend", 1, 32'h1);

        // Reset mid-count with INTR high; CTRL rewrite must not restart CNT
        tick(B + 32'h60, 32'd5, 1, "mc_ctrl", 0, 0);
        tick(B + 32'h64, 32'h20, 1, "mc_cmp", 0, 0);
        for (int i = 0; i < 8; i++) tick(B + 32'h68, 0, 0, "mc_cnt", 1, i);
        tick(B + 32'h60, 32'd5, 1, "mc_rewr", 1, 32'h5);
        for (int i = 9; i < 16; i++) tick(B + 32'h68, 0, 0, "mc_cnt2", 1, i);
        tick(B + 32'h68, 0, 0, "mc_at10", 1, 32'h10);
        RESET = 1'b1;
        tick(B + 32'h20, 32'hFFFF, 1, "mc_rst", 1, 32'h0000_A5A5);
        RESET = 1'b0;
        tick(B + 32'h68, 0, 0, "mc_cnt0", 1, 32'h0);
        tick(B + 32'h60, 0, 0, "mc_ctrl0", 1, 32'h0);
        tick(B + 32'h20, 0, 0, "mc_leds0", 1, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int          k;
            logic [31:0] d;
            logic        w;
            k = $urandom_range(0, 10);
            w = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (offs[k] == 32'h64) d = $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom);
            RESET = ($urandom_range(0, 79) == 0);
            tick(B + offs[k], d, w, "random", 0, 0);
        end
        RESET = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
